jtag_tap_driver: RTL and testbench
==================================

Name: jtag_tap_driver

Overview:
- Host-side JTAG master: generates tck/tms/tdi and samples tdo to steer a target TAP (built per the team's 16-state TAP controller) through reset, IR scans, DR scans and Run-Test/Idle dwell.
- Keeps a mirror of the target TAP state using the global TAP state encoding, so benches can compare it against a target TAP controller instance.
- Sits between the test-controller command logic and the physical JTAG pins.

Parameters:
- TCK_DIV, 2, clk cycles per tck half-period (>=1); tck period = 2*TCK_DIV clk.
- MAX_LEN, 32, maximum scan length in bits; width of cmd_data/rsp_data.
- LEN_W, 6, width of cmd_len (must hold MAX_LEN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  driver idle; a command is accepted on a clk edge where cmd_valid && cmd_ready.
- cmd_op  in  2  00 TAP reset, 01 shift IR, 10 shift DR, 11 run-idle.
- cmd_len  in  LEN_W  bits to shift (ops 01/10) or tck cycles to dwell (op 11); ignored for op 00.
- cmd_data  in  MAX_LEN  tdi data, LSB shifted first.
- rsp_valid  out  1  one-clk pulse at command completion.
- rsp_data  out  MAX_LEN  captured tdo bits, right-justified; held until next completion.
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to target.
- tdo  in  1  JTAG data from target.
- tap_state  out  `tap_state_width  mirrored target TAP state.

Behaviour:
- Reset values: tck 0, tms 1, tdi 0, cmd_ready 1, rsp_valid 0, rsp_data 0, tap_state TAP_TEST_LOGIG_RESET. The mirror is valid only if the target was also reset; otherwise the host issues op 00 first.
- Reset mid-command aborts immediately to the reset values. No response is generated.
- cmd_op, cmd_len and cmd_data are latched on acceptance. cmd_ready is 0 from the acceptance edge until the clk of rsp_valid, inclusive.
- tck timing: each tck period is a low phase of TCK_DIV clk followed by a high phase of TCK_DIV clk.
  - tms and tdi update only at the start of the low phase.
  - tdo is registered on the clk edge where tck goes 0->1.
  - tap_state advances on that same edge using the standard TAP transition on the current tms.
- FSM states: IDLE, PREFIX, SHIFT, SUFFIX, RUN, DONE.
- Op 00 (TAP reset): tms sequence 1,1,1,1,1,0, i.e. 6 tck periods. Ends in RUN_TEST_IDLE. rsp_data is set to 0.
- Ops 01/10/11 starting from TEST_LOGIG_RESET: one extra prefix tck with tms=0 goes to RUN_TEST_IDLE first.
- Op 01 (shift IR) from RUN_TEST_IDLE:
  - Prefix tms 1,1,0,0 (SELECT_DR, SELECT_IR, CAPTURE_IR, SHIFT_IR).
  - Then len shift periods: tms=0 for all but the last; the last has tms=1 (EXIT1).
  - Suffix tms 1,0 (UPDATE, RUN_TEST_IDLE).
- Op 10 (shift DR): same as op 01, but the prefix is tms 1,0,0.
- Shift bit i (0..len-1):
  - tdi = cmd_data[i].
  - rsp_data[i] = tdo sampled on that period's rising tck.
  - rsp_data bits >= len read 0.
  - tdi returns to 0 outside shift periods.
- len=0 for ops 01/10: after CAPTURE, one tms=1 period goes to EXIT1 with no bit shifted, then the suffix follows. rsp_data = 0.
- len > MAX_LEN is clamped to MAX_LEN.
- Op 11 (run-idle): len periods with tms=0 in RUN_TEST_IDLE. len=0 means no tck periods; rsp_valid follows acceptance within 2 clk.
- Completion: rsp_valid pulses for 1 clk after the high phase of the final tck period ends. tck is 0 and tap_state is RUN_TEST_IDLE at that point.
- While IDLE, tck holds 0 and tms holds its last value.
- cmd_valid while busy is ignored; it is not queued.

Test Plan:
- Reset then op 00 -> 6 tck periods, tms = 1,1,1,1,1,0; tap_state = RUN_TEST_IDLE; rsp_valid 1 clk; rsp_data=0. With TCK_DIV=2, tck is exactly 24 clk.
- From RUN_TEST_IDLE, op 01 len 8, data 0xA5, tdo looped to tdi through an 8-bit delay preloaded with 0x3C -> 14 tck periods; tdi bits 1,0,1,0,0,1,0,1; rsp_data=0x3C; tap_state path matches a target TAP controller instance (trst_n = ~reset) every period.
- Immediately after reset (mirror TEST_LOGIG_RESET), op 10 len 32, data 0xDEADBEEF, tdo=tdi -> 38 tck periods (1 extra prefix); rsp_data=0xDEADBEEF.
- Op 10 len 0 -> tms 1,0,1,1,0 (5 periods); no shift period; rsp_data=0. Op 11 len 0 -> no tck toggles; rsp_valid within 2 clk.
- Assert reset in the middle of a DR shift (bit 10 of 32) -> same clk: tck 0, tms 1, tdi 0, cmd_ready 1, tap_state TEST_LOGIG_RESET; no rsp_valid; the next op 01 runs correctly.
- Op 11 len 5, with cmd_valid pulsed again while busy -> exactly 5 tck periods with tms=0; second request ignored; cmd_ready 0 throughout.

Source files
------------

// File: rtl/jtag_tap_driver.sv
// Host-side JTAG master: turns reset / IR scan / DR scan / run-idle commands into
// tck/tms/tdi waveforms, captures tdo and mirrors the target TAP state.
`timescale 1ns/1ps
`ifndef TAP_STATE_WIDTH
`define TAP_STATE_WIDTH 4
`endif

module jtag_tap_driver #(
    parameter int TCK_DIV = 2,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [LEN_W-1:0]            cmd_len,
    input  logic [MAX_LEN-1:0]          cmd_data,
    output logic                        rsp_valid,
    output logic [MAX_LEN-1:0]          rsp_data,
    output logic                        tck,
    output logic                        tms,
    output logic                        tdi,
    input  logic                        tdo,
    output logic [`TAP_STATE_WIDTH-1:0] tap_state
);

    localparam int TW    = `TAP_STATE_WIDTH;
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    localparam logic [TW-1:0] TAP_TEST_LOGIG_RESET = TW'(0);
    localparam logic [TW-1:0] TAP_RUN_TEST_IDLE    = TW'(1);
    localparam logic [TW-1:0] TAP_SELECT_DR        = TW'(2);
    localparam logic [TW-1:0] TAP_CAPTURE_DR       = TW'(3);
    localparam logic [TW-1:0] TAP_SHIFT_DR         = TW'(4);
    localparam logic [TW-1:0] TAP_EXIT1_DR         = TW'(5);
    localparam logic [TW-1:0] TAP_PAUSE_DR         = TW'(6);
    localparam logic [TW-1:0] TAP_EXIT2_DR         = TW'(7);
    localparam logic [TW-1:0] TAP_UPDATE_DR        = TW'(8);
    localparam logic [TW-1:0] TAP_SELECT_IR        = TW'(9);
    localparam logic [TW-1:0] TAP_CAPTURE_IR       = TW'(10);
    localparam logic [TW-1:0] TAP_SHIFT_IR         = TW'(11);
    localparam logic [TW-1:0] TAP_EXIT1_IR         = TW'(12);
    localparam logic [TW-1:0] TAP_PAUSE_IR         = TW'(13);
    localparam logic [TW-1:0] TAP_EXIT2_IR         = TW'(14);
    localparam logic [TW-1:0] TAP_UPDATE_IR        = TW'(15);

    typedef enum logic [2:0] {
        S_IDLE, S_PREFIX, S_SHIFT, S_SUFFIX, S_RUN, S_DONE
    } state_t;

    function automatic logic [TW-1:0] tap_next(input logic [TW-1:0] s, input logic m);
        case (s)
            TAP_TEST_LOGIG_RESET: tap_next = m ? TAP_TEST_LOGIG_RESET : TAP_RUN_TEST_IDLE;
            TAP_RUN_TEST_IDLE:    tap_next = m ? TAP_SELECT_DR  : TAP_RUN_TEST_IDLE;
            TAP_SELECT_DR:        tap_next = m ? TAP_SELECT_IR  : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR:       tap_next = m ? TAP_EXIT1_DR   : TAP_SHIFT_DR;
            TAP_SHIFT_DR:         tap_next = m ? TAP_EXIT1_DR   : TAP_SHIFT_DR;
            TAP_EXIT1_DR:         tap_next = m ? TAP_UPDATE_DR  : TAP_PAUSE_DR;
            TAP_PAUSE_DR:         tap_next = m ? TAP_EXIT2_DR   : TAP_PAUSE_DR;
            TAP_EXIT2_DR:         tap_next = m ? TAP_UPDATE_DR  : TAP_SHIFT_DR;
            TAP_UPDATE_DR:        tap_next = m ? TAP_SELECT_DR  : TAP_RUN_TEST_IDLE;
            TAP_SELECT_IR:        tap_next = m ? TAP_TEST_LOGIG_RESET : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR:       tap_next = m ? TAP_EXIT1_IR   : TAP_SHIFT_IR;
            TAP_SHIFT_IR:         tap_next = m ? TAP_EXIT1_IR   : TAP_SHIFT_IR;
            TAP_EXIT1_IR:         tap_next = m ? TAP_UPDATE_IR  : TAP_PAUSE_IR;
            TAP_PAUSE_IR:         tap_next = m ? TAP_EXIT2_IR   : TAP_PAUSE_IR;
            TAP_EXIT2_IR:         tap_next = m ? TAP_UPDATE_IR  : TAP_SHIFT_IR;
            TAP_UPDATE_IR:        tap_next = m ? TAP_SELECT_DR  : TAP_RUN_TEST_IDLE;
            default:              tap_next = TAP_TEST_LOGIG_RESET;
        endcase
    endfunction

    state_t               state;
    logic [DIV_W-1:0]     div;
    logic [5:0]           pre_seq;
    logic [2:0]           pre_left;
    logic [LEN_W-1:0]     sh_left;
    logic [1:0]           suf_left;
    logic [LEN_W-1:0]     run_left;
    logic [MAX_LEN-1:0]   data_q;
    logic [MAX_LEN-1:0]   cap;
    logic [LEN_W-1:0]     sh_idx;

    logic                 accept, active, edge_due, rise, fall, launch;
    logic [LEN_W-1:0]     len_c;
    logic [5:0]           f_seq, src_seq, l_seq;
    logic [2:0]           f_pre, src_pre, l_pre;
    logic [LEN_W-1:0]     f_sh, src_sh, l_sh;
    logic [1:0]           f_suf, src_suf, l_suf;
    logic [LEN_W-1:0]     f_run, src_run, l_run;
    logic [MAX_LEN-1:0]   src_data, l_data;
    state_t               l_state;
    logic                 l_tms, l_tdi;

    always_comb begin
        accept   = (state == S_IDLE) && cmd_valid;
        active   = (state == S_PREFIX) || (state == S_SHIFT) ||
                   (state == S_SUFFIX) || (state == S_RUN);
        edge_due = active && (div == DIV_W'(TCK_DIV - 1));
        rise     = edge_due && !tck;
        fall     = edge_due && tck;
        launch   = accept || fall;
    end

    // Work plan for a freshly accepted command; prefix tms bits are stored LSB first.
    always_comb begin
        len_c = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
        f_seq = '0;
        f_pre = '0;
        f_sh  = '0;
        f_suf = '0;
        f_run = '0;
        case (cmd_op)
            2'b00: begin
                f_seq = 6'b011111;
                f_pre = 3'd6;
            end
            2'b01: begin
                f_seq = {2'b00, (len_c == '0) ? 4'b1011 : 4'b0011};
                f_pre = 3'd4;
                f_sh  = len_c;
                f_suf = 2'd2;
            end
            2'b10: begin
                f_seq = {3'b000, (len_c == '0) ? 3'b101 : 3'b001};
                f_pre = 3'd3;
                f_sh  = len_c;
                f_suf = 2'd2;
            end
            default: f_run = len_c;
        endcase
        if (cmd_op != 2'b00 && tap_state == TAP_TEST_LOGIG_RESET) begin
            f_seq = {f_seq[4:0], 1'b0};
            f_pre = f_pre + 3'd1;
        end
    end

    // Pick the next tck period from the remaining work and consume it.
    always_comb begin
        src_seq  = accept ? f_seq    : pre_seq;
        src_pre  = accept ? f_pre    : pre_left;
        src_sh   = accept ? f_sh     : sh_left;
        src_suf  = accept ? f_suf    : suf_left;
        src_run  = accept ? f_run    : run_left;
        src_data = accept ? cmd_data : data_q;
        l_state  = S_DONE;
        l_tms    = tms;
        l_tdi    = 1'b0;
        l_seq    = src_seq;
        l_pre    = src_pre;
        l_sh     = src_sh;
        l_suf    = src_suf;
        l_run    = src_run;
        l_data   = src_data;
        if (src_pre != 3'd0) begin
            l_state = S_PREFIX;
            l_tms   = src_seq[0];
            l_seq   = src_seq >> 1;
            l_pre   = src_pre - 3'd1;
        end else if (src_sh != '0) begin
            l_state = S_SHIFT;
            l_tms   = (src_sh == LEN_W'(1));
            l_tdi   = src_data[0];
            l_data  = src_data >> 1;
            l_sh    = src_sh - LEN_W'(1);
        end else if (src_suf != 2'd0) begin
            l_state = S_SUFFIX;
            l_tms   = (src_suf == 2'd2);
            l_suf   = src_suf - 2'd1;
        end else if (src_run != '0) begin
            l_state = S_RUN;
            l_tms   = 1'b0;
            l_run   = src_run - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            div       <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            tap_state <= TAP_TEST_LOGIG_RESET;
            pre_seq   <= '0;
            pre_left  <= '0;
            sh_left   <= '0;
            suf_left  <= '0;
            run_left  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (active)
                div <= edge_due ? '0 : div + DIV_W'(1);
            if (rise) begin
                tck       <= 1'b1;
                tap_state <= tap_next(tap_state, tms);
            end
            if (launch) begin
                tck       <= 1'b0;
                tms       <= l_tms;
                tdi       <= l_tdi;
                state     <= l_state;
                cmd_ready <= 1'b0;
                pre_seq   <= l_seq;
                pre_left  <= l_pre;
                sh_left   <= l_sh;
                suf_left  <= l_suf;
                run_left  <= l_run;
                if (l_state == S_DONE) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= accept ? '0 : cap;
                end
            end
            if (state == S_DONE) begin
                state     <= S_IDLE;
                cmd_ready <= 1'b1;
            end
        end
    end

    // Shift data and capture register: cleared per command, no reset needed.
    always_ff @(posedge clk) begin
        if (launch)
            data_q <= l_data;
        if (accept) begin
            cap    <= '0;
            sh_idx <= '0;
        end else if (rise && state == S_SHIFT) begin
            cap    <= cap | ({{(MAX_LEN-1){1'b0}}, tdo} << sh_idx);
            sh_idx <= sh_idx + LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver: a target TAP model on the pins, a per-command
// tms/tdi sequence model, and directed commands with hand-computed results.
`timescale 1ns/1ps
`ifndef TAP_STATE_WIDTH
`define TAP_STATE_WIDTH 4
`endif

module tb_jtag_tap_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tck, tms, tdi, tdo;
    logic [`TAP_STATE_WIDTH-1:0] tap_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;
    bit mir_tlr = 1;

    // Target TAP: next state for tms=0 / tms=1, indexed by state code.
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int tstate = 0;
    logic       tdo_mode = 1'b0;
    logic [7:0] dly = 8'h00;
    bit trace_tms[$];
    bit trace_tdi[$];
    bit exp_tms[$];
    bit exp_tdi[$];

    jtag_tap_driver #(.TCK_DIV(2), .MAX_LEN(32), .LEN_W(6)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tap_state(tap_state)
    );

    always #5 clk = ~clk;

    assign tdo = tdo_mode ? dly[0] : tdi;

    always @(posedge tck or posedge reset) begin
        if (reset) begin
            tstate = 0;
        end else begin
            if (tstate == 11)
                dly = {tdi, dly[7:1]};
            trace_tms.push_back(tms);
            trace_tdi.push_back(tdi);
            tstate = tms ? nxt1[tstate] : nxt0[tstate];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mirror must track the independent target TAP on every clk.
    always @(negedge clk) begin
        if (started) begin
            n_tests++;
            if (int'(tap_state) != tstate) begin
                n_fail++;
                $display("FAIL tap_state_track: got %0d, expected %0d at %0t", tap_state, tstate, $time);
            end
        end
    end

    task automatic push_exp(input bit m, input bit d);
        exp_tms.push_back(m);
        exp_tdi.push_back(d);
    endtask

    // Expected tms/tdi per tck period, from the command rules.
    task automatic build_expect(input logic [1:0] op, input int len, input logic [31:0] data, input bit from_tlr);
        int n;
        exp_tms.delete();
        exp_tdi.delete();
        n = (len > 32) ? 32 : len;
        if (op == 2'b00) begin
            for (int i = 0; i < 5; i++) push_exp(1, 0);
            push_exp(0, 0);
            return;
        end
        if (from_tlr) push_exp(0, 0);
        if (op == 2'b11) begin
            for (int i = 0; i < n; i++) push_exp(0, 0);
            return;
        end
        push_exp(1, 0);
        if (op == 2'b01) push_exp(1, 0);
        push_exp(0, 0);
        if (n == 0) begin
            push_exp(1, 0);
        end else begin
            push_exp(0, 0);
            for (int i = 0; i < n; i++) push_exp(i == n - 1, data[i]);
        end
        push_exp(1, 0);
        push_exp(0, 0);
    endtask

    function automatic logic [63:0] pack_q(input bit q[$], input int start, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            if (start + i < q.size()) v[i] = q[start + i];
        return v;
    endfunction

    task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                           input logic [31:0] exp_rsp, input int exp_periods, input int poke,
                           output int cycles);
        int viol, mis_tms, mis_tdi, lim;
        bit done;
        build_expect(op, len, data, mir_tlr);
        trace_tms.delete();
        trace_tdi.delete();
        @(negedge clk);
        check("ready_before", cmd_ready, 1);
        cmd_op = op; cmd_len = 6'(len); cmd_data = data; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cycles = 0; viol = 0; done = 0;
        while (!done && cycles < 3000) begin
            @(negedge clk);
            if (rsp_valid) begin
                done = 1;
            end else begin
                if (cmd_ready) viol++;
                cycles++;
                if (poke != 0) begin
                    cmd_valid = (cycles == poke);
                    cmd_op = 2'b00;
                end
            end
        end
        cmd_valid = 1'b0;
        check("rsp_seen", done, 1);
        if (done) begin
            check("ready_low_while_busy", viol, 0);
            check("ready_at_rsp", cmd_ready, 0);
            check("tck_at_rsp", tck, 0);
            check("state_at_rsp", tap_state, 1);
            check("rsp_data", rsp_data, exp_rsp);
            check("periods_literal", trace_tms.size(), exp_periods);
            check("periods_model", trace_tms.size(), exp_tms.size());
            mis_tms = 0; mis_tdi = 0;
            lim = (trace_tms.size() < exp_tms.size()) ? trace_tms.size() : exp_tms.size();
            for (int i = 0; i < lim; i++) begin
                if (trace_tms[i] != exp_tms[i]) mis_tms++;
                if (trace_tdi[i] != exp_tdi[i]) mis_tdi++;
            end
            check("tms_sequence", mis_tms, 0);
            check("tdi_sequence", mis_tdi, 0);
            @(negedge clk);
            check("rsp_pulse_1clk", rsp_valid, 0);
            check("ready_after", cmd_ready, 1);
        end
        mir_tlr = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, k, rsp_cnt;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        started = 1;
        check("rst_tck", tck, 0);
        check("rst_tms", tms, 1);
        check("rst_tdi", tdi, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_tap_state", tap_state, 0);
        reset = 1'b0;
        mir_tlr = 1;

        run_cmd(2'b00, 0, 32'h0, 32'h0, 6, 0, cyc);
        check("op00_tms_literal", pack_q(trace_tms, 0, 6), 64'h1F);
        check("op00_24clk", cyc, 24);

        tdo_mode = 1'b1;
        dly = 8'h3C;
        run_cmd(2'b01, 8, 32'hA5, 32'h3C, 14, 0, cyc);
        check("ir_tdi_bits_literal", pack_q(trace_tdi, 4, 8), 64'hA5);
        tdo_mode = 1'b0;

        run_cmd(2'b10, 0, 32'hFFFF_FFFF, 32'h0, 5, 0, cyc);
        check("dr_len0_tms_literal", pack_q(trace_tms, 0, 5), 64'h0D);

        run_cmd(2'b11, 0, 32'h0, 32'h0, 0, 0, cyc);
        check("run0_latency", cyc <= 1, 1);

        run_cmd(2'b11, 5, 32'h0, 32'h0, 5, 5, cyc);
        check("run5_tms_literal", pack_q(trace_tms, 0, 5), 64'h0);
        repeat (20) @(negedge clk);
        check("busy_request_ignored", trace_tms.size(), 5);

        run_cmd(2'b10, 12, 32'hFFFF_FFFF, 32'h0000_0FFF, 17, 0, cyc);
        run_cmd(2'b10, 40, 32'h1234_5678, 32'h1234_5678, 37, 0, cyc);

        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        mir_tlr = 1;
        run_cmd(2'b10, 32, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 38, 0, cyc);

        // Abort during bit 10 of a 32-bit DR shift started from Test-Logic-Reset.
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        mir_tlr = 1;
        trace_tms.delete();
        trace_tdi.delete();
        @(negedge clk);
        cmd_op = 2'b10; cmd_len = 6'd32; cmd_data = 32'hDEAD_BEEF; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        k = 0;
        while (trace_tms.size() < 14 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached_bit10", trace_tms.size() >= 14, 1);
        k = 0;
        while (tck && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("abort_pre_tdi_bit10", tdi, 1);
        check("abort_pre_tms", tms, 0);
        #2 reset = 1'b1;
        #1;
        check("abort_tck", tck, 0);
        check("abort_tms", tms, 1);
        check("abort_tdi", tdi, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_tap_state", tap_state, 0);
        rsp_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
        end
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
        end
        check("abort_no_rsp", rsp_cnt, 0);
        mir_tlr = 1;
        run_cmd(2'b01, 8, 32'h5A, 32'h5A, 15, 0, cyc);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
